// File: rtl/veririsc_fetch_seq.sv
// Phase sequencer and fetch datapath for the VeriRISC core.
// Generates the 4-phase instruction cycle and holds the instruction register
// and program counter. It also drives the memory address and counts retired
// instructions.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   mem_data      instruction/data word returned by memory
//   mem_ready     mem_data is valid this cycle
//   ld_ir         load ir_out from mem_data (honoured only in fetch with mem_ready)
//   inc_pc        increment pc
//   ld_pc         load pc from ir_out operand field (priority over inc_pc)
//   halt          stop the machine (sticky until reset)
//   phase         00 fetch, 01 decode, 10 execute, 11 writeback
//   ir_out        instruction register
//   pc            program counter
//   addr          memory address (combinational): pc in fetch, else operand
//   halted        sticky halt status
//   instr_count   saturating retired-instruction counter
module veririsc_fetch_seq #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              mem_ready,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              halt,
  output logic [1:0]        phase,
  output logic [DWIDTH-1:0] ir_out,
  output logic [AWIDTH-1:0] pc,
  output logic [AWIDTH-1:0] addr,
  output logic              halted,
  output logic [CWIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    PH_FETCH  = 2'b00,
    PH_DECODE = 2'b01,
    PH_EXEC   = 2'b10,
    PH_WB     = 2'b11
  } phase_e;

  localparam logic [CWIDTH-1:0] CNT_MAX = '1;

  phase_e state;

  assign phase = state;

  // Address mux: instruction fetch uses pc, later phases use the operand field.
  always_comb begin
    addr = ir_out[AWIDTH-1:0];
    if (state == PH_FETCH) begin
      addr = pc;
    end
  end

  // Phase FSM plus fetch datapath; halt freezes everything until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PH_FETCH;
      ir_out      <= '0;
      pc          <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else if (!halted) begin
      if (halt) begin
        halted <= 1'b1;
      end else begin
        // IR captures only a valid memory word during fetch.
        if (state == PH_FETCH && ld_ir && mem_ready) begin
          ir_out <= mem_data;
        end

        // Jump target comes from the pre-edge IR value.
        if (ld_pc) begin
          pc <= ir_out[AWIDTH-1:0];
        end else if (inc_pc) begin
          pc <= pc + AWIDTH'(1);
        end

        case (state)
          PH_FETCH: begin
            if (mem_ready) begin
              state <= PH_DECODE;
            end
          end
          PH_DECODE: state <= PH_EXEC;
          PH_EXEC:   state <= PH_WB;
          PH_WB: begin
            state <= PH_FETCH;
            if (instr_count != CNT_MAX) begin
              instr_count <= instr_count + CWIDTH'(1);
            end
          end
          default: state <= PH_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_veririsc_fetch_seq.sv
// Self-checking bench for veririsc_fetch_seq: directed scenarios followed by
// randomized traffic, compared every cycle against an abstract model.
module tb_veririsc_fetch_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       halt;

  logic [1:0]  phase,  phase4;
  logic [7:0]  ir_out, ir_out4;
  logic [4:0]  pc,     pc4;
  logic [4:0]  addr,   addr4;
  logic        halted, halted4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  int vectors;
  int miscompares;

  // Reference model state
  int m_phase;
  int m_ir;
  int m_pc;
  int m_halted;
  int m_cnt16;
  int m_cnt4;

  veririsc_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .mem_data(mem_data), .mem_ready(mem_ready),
    .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .halt(halt),
    .phase(phase), .ir_out(ir_out), .pc(pc), .addr(addr),
    .halted(halted), .instr_count(instr_count)
  );

  veririsc_fetch_seq #(.AWIDTH(5), .DWIDTH(8), .CWIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_data(mem_data), .mem_ready(mem_ready),
    .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .halt(halt),
    .phase(phase4), .ir_out(ir_out4), .pc(pc4), .addr(addr4),
    .halted(halted4), .instr_count(instr_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ir = 0; m_pc = 0; m_halted = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  // One rising edge of the abstract machine, using the currently driven inputs.
  task automatic model_edge();
    int old_ir;
    if (m_halted != 0) return;
    if (halt) begin
      m_halted = 1;
      return;
    end
    old_ir = m_ir;
    if (m_phase == 0 && ld_ir && mem_ready) m_ir = int'(mem_data);
    if (ld_pc)       m_pc = old_ir % 32;
    else if (inc_pc) m_pc = (m_pc + 1) % 32;
    if (m_phase == 3) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
    if (m_phase != 0 || mem_ready) m_phase = (m_phase + 1) % 4;
  endtask

  task automatic check_all();
    int exp_addr;
    exp_addr = (m_phase == 0) ? m_pc : (m_ir % 32);
    check("phase",       32'(phase),        32'(m_phase));
    check("ir_out",      32'(ir_out),       32'(m_ir));
    check("pc",          32'(pc),           32'(m_pc));
    check("addr",        32'(addr),         32'(exp_addr));
    check("halted",      32'(halted),       32'(m_halted));
    check("instr_count", 32'(instr_count),  32'(m_cnt16));
    check("phase_c4",    32'(phase4),       32'(m_phase));
    check("count_c4",    32'(instr_count4), 32'(m_cnt4));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic mr, input logic [7:0] md, input logic li,
                        input logic ip, input logic lp, input logic h);
    mem_ready = mr; mem_data = md; ld_ir = li; inc_pc = ip; ld_pc = lp; halt = h;
  endtask

  // Asynchronous reset pulse launched between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic instruction: A5 fetched, four phases, one retirement.
    set_in(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("ir_a5", 32'(ir_out), 32'h0000_00A5);
    set_in(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("phase_wb", 32'(phase), 32'd3);
    step();
    check("retire_1", 32'(instr_count), 32'd1);
    check("phase_wrap", 32'(phase), 32'd0);

    // Memory wait: ld_ir without mem_ready must not load.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("wait_addr_is_pc", 32'(addr), 32'(pc));
    end
    set_in(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("ir_3c", 32'(ir_out), 32'h0000_003C);

    // ld_pc wins over inc_pc: pc gets ir[4:0] = 0x1C.
    set_in(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("ld_pc_prio", 32'(pc), 32'h0000_001C);

    // Increment up to 31, then wrap to 0.
    set_in(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64 && m_pc != 31; i++) step();
    check("pc_31", 32'(pc), 32'd31);
    step();
    check("pc_wrap", 32'(pc), 32'd0);

    // Advance to execute, then halt with inc_pc asserted.
    set_in(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && m_phase != 2; i++) step();
    check("pre_halt_phase", 32'(phase), 32'd2);
    set_in(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("halted_set", 32'(halted), 32'd1);
    check("halt_phase", 32'(phase), 32'd2);
    for (int i = 0; i < 20; i++) begin
      set_in(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      check("frozen_phase", 32'(phase), 32'd2);
    end

    // Reset while halted, then fetch restarts at pc 0.
    pulse_reset();
    set_in(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_addr", 32'(addr), 32'd0);
    step();
    // Reset in the middle of decode.
    pulse_reset();

    // Saturation: 17 instructions on the 4-bit counter.
    set_in(1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17 * 4; i++) step();
    check("sat_c4", 32'(instr_count4), 32'd15);
    check("count16_17", 32'(instr_count), 32'd17);

    // Randomized traffic with occasional halt and reset.
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 149) == 0));
      if ((m_halted != 0 && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0)
        pulse_reset();
      else
        step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
